// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared types and helpers for the multi-port register file.
//   rf_state_e  : clear-sequencer states (RF_CLEAR while zeroing, RF_RUN after)
//   rf_wr_sel_t : result of write-port arbitration (hit flag + winning port)
//   rf_wr_sel() : picks the write port that targets a given address
package regfile_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_e;

  // Arbitration works on fixed maximum widths so one function serves every
  // parameterisation; callers zero-extend their addresses and enables.
  localparam int RF_MAX_NW = 16;
  localparam int RF_MAX_AW = 16;
  localparam int RF_IDX_W  = $clog2(RF_MAX_NW);

  typedef struct packed {
    logic                hit;
    logic [RF_IDX_W-1:0] idx;
  } rf_wr_sel_t;

  // Scans ports from low to high so the highest-index enabled port that
  // matches the address is the one reported.
  function automatic rf_wr_sel_t rf_wr_sel(
    input logic [RF_MAX_AW-1:0]           addr,
    input logic [RF_MAX_NW-1:0]           wren,
    input logic [RF_MAX_NW*RF_MAX_AW-1:0] waddr
  );
    rf_wr_sel_t sel;
    sel.hit = 1'b0;
    sel.idx = '0;
    for (int j = 0; j < RF_MAX_NW; j++) begin
      if (wren[j] && (waddr[j*RF_MAX_AW +: RF_MAX_AW] == addr)) begin
        sel.hit = 1'b1;
        sel.idx = RF_IDX_W'(j);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/regfile_clr_ctrl.sv
// regfile_clr_ctrl
// Clear sequencer: after reset, walks every register address once so the
// storage array is zeroed before the datapath may use it.
// Ports:
//   clk      in   clock
//   rst      in   synchronous reset, active-high; restarts the sweep at 0
//   clr_en   out  1 while a register is being cleared this cycle
//   clr_addr out  address being cleared
//   o_busy   out  1 until the sweep has completed
module regfile_clr_ctrl #(
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          clr_en,
  output logic [AW-1:0] clr_addr,
  output logic          o_busy
);
  import regfile_pkg::*;

  rf_state_e     state, state_next;
  logic [AW-1:0] clr_cnt, cnt_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RF_CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_next;
      clr_cnt <= cnt_next;
    end
  end

  // The last address is cleared on the same edge that moves to RF_RUN, so
  // the sweep lasts exactly NREGS cycles.
  always_comb begin
    state_next = state;
    cnt_next   = clr_cnt;
    clr_en     = 1'b0;
    case (state)
      RF_CLEAR: begin
        clr_en   = 1'b1;
        cnt_next = clr_cnt + AW'(1);
        if (clr_cnt == AW'(NREGS - 1)) begin
          state_next = RF_RUN;
        end
      end
      RF_RUN: begin
        state_next = RF_RUN;
      end
      default: begin
        state_next = RF_CLEAR;
      end
    endcase
  end

  assign clr_addr = clr_cnt;
  assign o_busy   = (state != RF_RUN);

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp
// Parametrised multi-port integer register file with optional write-to-read
// bypass, optional hardwired register 0 and a self-clearing sequencer.
// Ports:
//   i_clk      in   clock
//   i_rst      in   synchronous reset, active-high
//   i_rs_addr  in   NR*AW read addresses, port k at [k*AW +: AW]
//   o_rs_data  out  NR*DW read data, port k at [k*DW +: DW]
//   i_rd_addr  in   NW*AW write addresses, port j at [j*AW +: AW]
//   i_rd_data  in   NW*DW write data, port j at [j*DW +: DW]
//   i_rd_wren  in   NW per-port write enables
//   o_busy     out  1 while the clear sequence runs (writes dropped, reads 0)
module regfile_mp #(
  parameter int DW       = 32,
  parameter int NREGS    = 32,
  parameter int AW       = $clog2(NREGS),
  parameter int NR       = 2,
  parameter int NW       = 1,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [NR*AW-1:0] i_rs_addr,
  output logic [NR*DW-1:0] o_rs_data,
  input  logic [NW*AW-1:0] i_rd_addr,
  input  logic [NW*DW-1:0] i_rd_data,
  input  logic [NW-1:0]    i_rd_wren,
  output logic             o_busy
);
  import regfile_pkg::*;

  logic [DW-1:0] regs [NREGS];

  logic          clr_en;
  logic [AW-1:0] clr_addr;

  regfile_clr_ctrl #(
    .NREGS(NREGS),
    .AW   (AW)
  ) u_clr_ctrl (
    .clk     (i_clk),
    .rst     (i_rst),
    .clr_en  (clr_en),
    .clr_addr(clr_addr),
    .o_busy  (o_busy)
  );

  // Effective enables already exclude busy cycles and writes to a hardwired
  // x0, so neither storage nor bypass can ever pick up such a write.
  logic [RF_MAX_NW-1:0]           wren_ext;
  logic [RF_MAX_NW*RF_MAX_AW-1:0] waddr_ext;

  always_comb begin
    wren_ext  = '0;
    waddr_ext = '0;
    for (int j = 0; j < NW; j++) begin
      waddr_ext[j*RF_MAX_AW +: RF_MAX_AW] = RF_MAX_AW'(i_rd_addr[j*AW +: AW]);
      wren_ext[j] = i_rd_wren[j] && !o_busy &&
                    !((ZERO_REG != 0) && (i_rd_addr[j*AW +: AW] == '0));
    end
  end

  rf_wr_sel_t reg_sel [NREGS];

  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      reg_sel[r] = rf_wr_sel(RF_MAX_AW'(r), wren_ext, waddr_ext);
    end
  end

  // Storage has no reset of its own; the clear sweep zeroes it instead.
  always_ff @(posedge i_clk) begin
    if (clr_en) begin
      regs[clr_addr] <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (reg_sel[r].hit) begin
          regs[r] <= i_rd_data[int'(reg_sel[r].idx)*DW +: DW];
        end
      end
    end
  end

  for (genvar k = 0; k < NR; k++) begin : g_rd
    logic [AW-1:0] ra;
    rf_wr_sel_t    byp;
    logic [DW-1:0] rd_val;

    assign ra  = i_rs_addr[k*AW +: AW];
    assign byp = rf_wr_sel(RF_MAX_AW'(ra), wren_ext, waddr_ext);

    // Priority: busy / hardwired zero, then bypass, then stored value.
    always_comb begin
      rd_val = regs[ra];
      if ((BYPASS != 0) && byp.hit) begin
        rd_val = i_rd_data[int'(byp.idx)*DW +: DW];
      end
      if (o_busy || ((ZERO_REG != 0) && (ra == '0))) begin
        rd_val = '0;
      end
    end

    assign o_rs_data[k*DW +: DW] = rd_val;
  end

endmodule
